// File: rtl/karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl
//
// Sequential N x N unsigned multiplier controller using one Karatsuba level.
// A single external combinational sub-multiplier of width H = N/2+1 is
// time-shared over three passes (z0 = lo*lo, z2 = hi*hi, z1 = sum*sum), and
// the product is recombined on the last pass.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  controller idle and able to accept operands
//   a, b       in   N-bit unsigned operands
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts result
//   r          out  2N-bit product, changes only on Z1->DONE and on reset
//   busy       out  high in any state other than IDLE
//   mul_u/v    out  H-bit sub-multiplier operands (0 in IDLE and DONE)
//   mul_r      in   2H-bit sub-multiplier product, same-cycle combinational
//   chk_err    out  (KARATSUBA_SEQ_SELFCHECK_EN only) sticky mismatch flag
//
// Optional feature macro: KARATSUBA_SEQ_SELFCHECK_EN
//   Adds chk_err, which compares each recombined product against a
//   behavioral a*b. Meant for simulation and bring-up only.
//
// N must be even and >= 4.
// ---------------------------------------------------------------------------
module karatsuba_seq_ctrl #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    r,
  output logic              busy,
  output logic [N/2:0]      mul_u,
  output logic [N/2:0]      mul_v,
  input  logic [N+1:0]      mul_r
`ifdef KARATSUBA_SEQ_SELFCHECK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int M = N / 2;   // half width
  localparam int H = M + 1;   // sub-multiplier operand width
  localparam int P = 2 * H;   // sub-multiplier product width
  localparam int W = 2 * N;   // result width

  typedef enum logic [2:0] {
    S_IDLE,
    S_Z0,
    S_Z2,
    S_Z1,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [P-1:0]   z0_q, z2_q;
  logic [W-1:0]   r_q;

  logic           accept;
  logic [M-1:0]   a_lo, a_hi, b_lo, b_hi;
  logic [P-1:0]   mid;
  logic [W-1:0]   prod;

  assign a_lo = a_q[M-1:0];
  assign a_hi = a_q[N-1:M];
  assign b_lo = b_q[M-1:0];
  assign b_hi = b_q[N-1:M];

  // in_ready drops combinationally while rst is high so nothing is taken
  // in the reset cycle.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign r         = r_q;

  // Middle term: (a_lo+a_hi)(b_lo+b_hi) - z2 - z0 = a_lo*b_hi + a_hi*b_lo,
  // which is non-negative and fits in P bits. Only valid during Z1, when
  // mul_r carries the sum product.
  assign mid  = mul_r - z2_q - z0_q;
  assign prod = (W'(z2_q) << N) + (W'(mid) << M) + W'(z0_q);

  // Next state and sub-multiplier operand selection
  always_comb begin
    state_d = state_q;
    mul_u   = '0;
    mul_v   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_Z0;
      end
      S_Z0: begin
        mul_u   = {1'b0, a_lo};
        mul_v   = {1'b0, b_lo};
        state_d = S_Z2;
      end
      S_Z2: begin
        mul_u   = {1'b0, a_hi};
        mul_v   = {1'b0, b_hi};
        state_d = S_Z1;
      end
      S_Z1: begin
        // Keep the carry: with all-ones halves the sum needs M+1 bits.
        mul_u   = H'(a_lo) + H'(a_hi);
        mul_v   = H'(b_lo) + H'(b_hi);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if (state_q == S_Z0) z0_q <= mul_r;
      if (state_q == S_Z2) z2_q <= mul_r;
      if (state_q == S_Z1) r_q  <= prod;
    end
  end

`ifdef KARATSUBA_SEQ_SELFCHECK_EN
  logic [W-1:0] ref_prod;
  logic         chk_err_q;

  assign ref_prod = W'(a_q) * W'(b_q);
  assign chk_err  = chk_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if ((state_q == S_Z1) && (prod != ref_prod)) begin
      chk_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_seq_ctrl
//
// Directed bench for karatsuba_seq_ctrl with N=16. Provides the external
// combinational sub-multiplier, drives and samples on the falling edge.
// Cycle counts below treat the accept cycle (IDLE with in_valid) as cycle 0.
// ---------------------------------------------------------------------------
module tb_karatsuba_seq_ctrl;

  localparam int N = 16;
  localparam int H = N / 2 + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a, b;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   r;
  logic             busy;
  logic [H-1:0]     mul_u, mul_v;
  logic [2*H-1:0]   mul_r;
`ifdef KARATSUBA_SEQ_SELFCHECK_EN
  logic             chk_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int last_acc = -1;

  karatsuba_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy),
    .mul_u     (mul_u),
    .mul_v     (mul_v),
    .mul_r     (mul_r)
`ifdef KARATSUBA_SEQ_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  // External sub-multiplier
  assign mul_r = (2*H)'(mul_u) * (2*H)'(mul_v);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT in IDLE; returns just
  // after a falling edge with the DUT back in IDLE. hold = cycles of
  // out_ready=0 in DONE, during which a competing in_valid is offered.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic [2*N-1:0] exp, input int hold,
                        input bit chk_rate);
    logic [H-1:0] su, sv;
    int cyc;
    bit seen;
    su = {1'b0, ta[7:0]}  + {1'b0, ta[15:8]};
    sv = {1'b0, tb_[7:0]} + {1'b0, tb_[15:8]};
    a         = ta;
    b         = tb_;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_mul_u", mul_u, 0);
    if (chk_rate && last_acc >= 0) chk("accept_period", cyc_cnt - last_acc, 5);
    last_acc = cyc_cnt;
    cyc  = 0;
    seen = 0;
    while (cyc < 12 && !seen) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      case (cyc)
        1: begin chk("z0_mul_u", mul_u, {1'b0, ta[7:0]});  chk("z0_mul_v", mul_v, {1'b0, tb_[7:0]});  end
        2: begin chk("z2_mul_u", mul_u, {1'b0, ta[15:8]}); chk("z2_mul_v", mul_v, {1'b0, tb_[15:8]}); end
        3: begin chk("z1_mul_u", mul_u, su);               chk("z1_mul_v", mul_v, sv);               end
        default: ;
      endcase
      if (out_valid) seen = 1;
    end
    chk("latency", cyc, 4);
    chk("result", r, exp);
    chk("done_mul_u", mul_u, 0);
    chk("done_mul_v", mul_v, 0);
    chk("done_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      a        = 16'hDEAD;
      b        = 16'hBEEF;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_r", r, exp);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_r_held", r, exp);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int vcount;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_u", mul_u, 0);
    chk("rst_mul_v", mul_v, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    run_op(16'h1234, 16'h5678, 32'h06260060, 0, 0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 0);
`ifdef KARATSUBA_SEQ_SELFCHECK_EN
    chk("chk_err_ones", chk_err, 0);
`endif
    run_op(16'h0000, 16'hABCD, 32'h00000000, 0, 0);
    run_op(16'h0001, 16'hFFFF, 32'h0000FFFF, 0, 0);
    run_op(16'h00FF, 16'h0100, 32'h0000FF00, 6, 0);

    // Reset while in Z2; r is nonzero beforehand so the clear is visible.
    a = 16'h0002; b = 16'h0009; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;       // Z0
    @(negedge clk);                        // Z2
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mul_u", mul_u, 0);
    chk("mid_rst_mul_v", mul_v, 0);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("no_valid_after_rst", vcount, 0);
    run_op(16'd3, 16'd5, 32'd15, 0, 0);

    // Back-to-back stream with out_ready high
    last_acc = -1;
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      run_op(ra, rb, (2*N)'(ra) * (2*N)'(rb), 0, 1);
    end
`ifdef KARATSUBA_SEQ_SELFCHECK_EN
    chk("chk_err_end", chk_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/karatsuba_seq_ctrl.md
Name: karatsuba_seq_ctrl

Overview:
Sequential controller that computes an N x N unsigned product with one Karatsuba level over three uses of a single shared sub-multiplier. The sub-multiplier is a combinational multiplier from the team's generator, width H = N/2+1, ports u, v, r. It is instantiated outside this block and driven through the mul_* ports. Trades area for latency in multiplier-heavy datapaths, with a valid/ready interface on both sides.

Parameters:
N, 16, operand width; must be even and >= 4. Output width is 2N. Sub-multiplier operand width is H = N/2+1, product width 2H.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands
a  in  N  operand A, unsigned
b  in  N  operand B, unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
r  out  2N  product a*b
busy  out  1  high in any state other than IDLE
mul_u  out  H  sub-multiplier operand u
mul_v  out  H  sub-multiplier operand v
mul_r  in  2H  sub-multiplier product, combinational from mul_u/mul_v, same cycle

Behaviour:
- Reset: state=IDLE, in_ready=0 during the rst cycle and 1 afterwards, out_valid=0, r=0, busy=0, mul_u=0, mul_v=0, internal z0/z1/z2 registers=0.
- Split: lo = low N/2 bits, hi = high N/2 bits of each registered operand.
- FSM states: IDLE, Z0, Z2, Z1, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register a and b, then go to Z0. No other state accepts input.
- Z0: mul_u={0,a_lo}, mul_v={0,b_lo}. Register z0=mul_r. Go to Z2.
- Z2: mul_u={0,a_hi}, mul_v={0,b_hi}. Register z2=mul_r. Go to Z1.
- Z1: mul_u=a_lo+a_hi, mul_v=b_lo+b_hi (N/2+1 bits each, carry kept).
  - Compute mid = mul_r - z2 - z0 in 2H bits. It is never negative.
  - Register r = (z2<<N) + (mid<<(N/2)) + z0, truncated to 2N bits. The true value never exceeds 2N bits.
  - Go to DONE.
- DONE: out_valid=1 and r held stable. When out_ready=1, go to IDLE with out_valid=0 the next cycle.
- mul_u and mul_v are 0 in IDLE and DONE.
- Latency: out_valid rises exactly 4 cycles after the accept edge.
- Throughput: with out_ready held high, one result per 5 cycles (accept, Z0, Z2, Z1, DONE).
- Backpressure: DONE holds r, out_valid and in_ready=0 indefinitely. r changes only on the Z1->DONE transition and on reset.
- in_valid with in_ready=0 is ignored. The source must hold its data; there is no buffering.
- rst in any state (including mid-Z2 or DONE) returns to the reset values on the next edge. The in-flight operation is discarded and no out_valid pulse is produced.
- Operand edge values (0, all ones) need no special casing. The carry in the Z1 sums is what keeps the all-ones case exact.

Optional Feature:
Macro KARATSUBA_SEQ_SELFCHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit), reset 0.
  - On the Z1->DONE edge the block compares the computed product against a behavioral a*b of the registered operands.
  - On mismatch, chk_err is set sticky until rst.
  - Intended for simulation and bring-up only.
- Undefined: the port and the comparison logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- N=16, a=0x1234, b=0x5678, out_ready=1 -> out_valid 4 cycles after accept, r=0x06260060; in_ready returns 1 the cycle after the DONE handshake.
- a=0xFFFF, b=0xFFFF -> r=0xFFFE0001. During Z1, mul_u=mul_v=0x1FE. chk_err stays 0 when the macro is defined.
- a=0x0000, b=0xABCD, then a=0x0001, b=0xFFFF -> r=0x00000000, then r=0x0000FFFF.
- Backpressure: out_ready=0 for 6 cycles in DONE -> r is stable, out_valid=1, in_ready=0, and a new in_valid is not accepted. out_ready=1 -> IDLE on the next edge.
- rst asserted for 1 cycle while in Z2 -> next cycle all outputs are at reset values and no out_valid appears. A following op a=3, b=5 gives r=15.
- Stream of 8 random operand pairs with in_valid and out_ready held at 1 -> accepts every 5 cycles, every r equals a*b, and mul_u/mul_v are 0 in IDLE and DONE.
